// File: rtl/l2_i_responder.sv
// L2 instruction-side responder: tag/valid/LRU bookkeeping for a 2-way
// set-associative L2 that services L1 I-cache refill requests, forwards misses
// to memory and signals completion back to the L1 with a one-cycle pulse.
module l2_i_responder #(
  parameter int TNUM_2 = 18,
  parameter int INUM_2 = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read_L1_L2,
  input  logic [INUM_2-1:0] index_L1_L2,
  input  logic [TNUM_2-1:0] tag_L1_L2,
  input  logic              flush,
  input  logic              ready_MEM_L2,
  output logic              ready_L2_L1,
  output logic              refill_L2,
  output logic              way_L2,
  output logic              read_L2_MEM,
  output logic [INUM_2-1:0] index_L2_MEM,
  output logic [TNUM_2-1:0] tag_L2_MEM,
  output logic              busy,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int NSETS = 1 << INUM_2;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COMPARE = 3'd1,
    S_MEM_REQ = 3'd2,
    S_REFILL  = 3'd3,
    S_RESPOND = 3'd4,
    S_GAP     = 3'd5
  } state_t;

  state_t state_q, state_d;

  // Per-set control state; one bit per set for each way plus the LRU pointer.
  logic [NSETS-1:0] valid0_q, valid0_d;
  logic [NSETS-1:0] valid1_q, valid1_d;
  logic [NSETS-1:0] lru_q, lru_d;

  // Latched request and miss bookkeeping.
  logic [INUM_2-1:0] idx_q, idx_d;
  logic [TNUM_2-1:0] tag_q, tag_d;
  logic              victim_q, victim_d;
  logic              flush_pend_q, flush_pend_d;
  logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;

  // Tag storage behaves as a RAM; its contents are only meaningful where the
  // matching valid bit is set, so it needs no reset.
  logic [TNUM_2-1:0] tag0_ram [NSETS];
  logic [TNUM_2-1:0] tag1_ram [NSETS];
  logic              tag_we;

  logic [TNUM_2-1:0] rd_tag0, rd_tag1;
  logic              hit0, hit1, hit;
  logic              flush_now;

  // Saturating increment: counters stick at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] one;
    one = {{(CNT_W-1){1'b0}}, 1'b1};
    return (v == {CNT_W{1'b1}}) ? v : v + one;
  endfunction

  // Tag lookup for the latched set, used during COMPARE.
  always_comb begin
    rd_tag0   = tag0_ram[idx_q];
    rd_tag1   = tag1_ram[idx_q];
    hit0      = valid0_q[idx_q] && (rd_tag0 == tag_q);
    hit1      = valid1_q[idx_q] && (rd_tag1 == tag_q);
    hit       = hit0 || hit1;
    flush_now = flush || flush_pend_q;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a pending flush in IDLE takes precedence over a request.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (!flush_now && read_L1_L2) state_d = S_COMPARE;
      S_COMPARE: state_d = hit ? S_RESPOND : S_MEM_REQ;
      S_MEM_REQ: if (ready_MEM_L2) state_d = S_REFILL;
      S_REFILL:  state_d = S_RESPOND;
      S_RESPOND: state_d = S_GAP;
      S_GAP:     state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Next values for latched request, valid/LRU arrays, flush tracking and counters.
  always_comb begin
    idx_d        = idx_q;
    tag_d        = tag_q;
    victim_d     = victim_q;
    valid0_d     = valid0_q;
    valid1_d     = valid1_q;
    lru_d        = lru_q;
    flush_pend_d = flush_pend_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    tag_we       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (flush_now) begin
          // Whole-cache invalidate in one cycle; the request, if any, waits.
          valid0_d     = '0;
          valid1_d     = '0;
          lru_d        = '0;
          flush_pend_d = 1'b0;
        end else if (read_L1_L2) begin
          idx_d = index_L1_L2;
          tag_d = tag_L1_L2;
        end
      end
      S_COMPARE: begin
        if (hit) begin
          // LRU points at the way that was not just used.
          lru_d[idx_q] = hit0;
          hit_cnt_d    = sat_inc(hit_cnt_q);
        end else begin
          // Fill an empty way first, otherwise replace the LRU way.
          if (!valid0_q[idx_q]) begin
            victim_d = 1'b0;
          end else if (!valid1_q[idx_q]) begin
            victim_d = 1'b1;
          end else begin
            victim_d = lru_q[idx_q];
          end
          miss_cnt_d = sat_inc(miss_cnt_q);
        end
      end
      S_REFILL: begin
        tag_we = 1'b1;
        if (victim_q) begin
          valid1_d[idx_q] = 1'b1;
        end else begin
          valid0_d[idx_q] = 1'b1;
        end
        lru_d[idx_q] = ~victim_q;
      end
      default: ;
    endcase

    // A flush seen while busy is remembered and applied once back in IDLE.
    if (state_q != S_IDLE && flush) begin
      flush_pend_d = 1'b1;
    end
  end

  // Control and latched-request registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid0_q     <= '0;
      valid1_q     <= '0;
      lru_q        <= '0;
      idx_q        <= '0;
      tag_q        <= '0;
      victim_q     <= 1'b0;
      flush_pend_q <= 1'b0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      valid0_q     <= valid0_d;
      valid1_q     <= valid1_d;
      lru_q        <= lru_d;
      idx_q        <= idx_d;
      tag_q        <= tag_d;
      victim_q     <= victim_d;
      flush_pend_q <= flush_pend_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  // Tag write on refill into the chosen victim way.
  always_ff @(posedge clk) begin
    if (tag_we) begin
      if (victim_q) begin
        tag1_ram[idx_q] <= tag_q;
      end else begin
        tag0_ram[idx_q] <= tag_q;
      end
    end
  end

  // Moore outputs decoded from registered state and latched values.
  always_comb begin
    busy         = (state_q != S_IDLE);
    read_L2_MEM  = (state_q == S_MEM_REQ);
    refill_L2    = (state_q == S_REFILL);
    way_L2       = (state_q == S_REFILL) && victim_q;
    ready_L2_L1  = (state_q == S_RESPOND);
    index_L2_MEM = idx_q;
    tag_L2_MEM   = tag_q;
    hit_cnt      = hit_cnt_q;
    miss_cnt     = miss_cnt_q;
  end

endmodule

// File: tb/tb_l2_i_responder.sv
// Bench for l2_i_responder: directed scenarios plus randomized requests,
// checked against a set/way/LRU reference model held in plain arrays.
module tb_l2_i_responder;

  localparam int TN = 18;
  localparam int IN = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          read_L1_L2;
  logic [IN-1:0] index_L1_L2;
  logic [TN-1:0] tag_L1_L2;
  logic          flush;
  logic          ready_MEM_L2;
  logic          ready_L2_L1;
  logic          refill_L2;
  logic          way_L2;
  logic          read_L2_MEM;
  logic [IN-1:0] index_L2_MEM;
  logic [TN-1:0] tag_L2_MEM;
  logic          busy;
  logic [CW-1:0] hit_cnt;
  logic [CW-1:0] miss_cnt;

  always #5 clk = ~clk;

  l2_i_responder #(.TNUM_2(TN), .INUM_2(IN), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .read_L1_L2(read_L1_L2), .index_L1_L2(index_L1_L2),
    .tag_L1_L2(tag_L1_L2), .flush(flush), .ready_MEM_L2(ready_MEM_L2),
    .ready_L2_L1(ready_L2_L1), .refill_L2(refill_L2), .way_L2(way_L2),
    .read_L2_MEM(read_L2_MEM), .index_L2_MEM(index_L2_MEM), .tag_L2_MEM(tag_L2_MEM),
    .busy(busy), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: which tags live in which way of each set, and LRU way.
  bit            mv0 [256];
  bit            mv1 [256];
  bit            ml  [256];
  logic [TN-1:0] mt0 [256];
  logic [TN-1:0] mt1 [256];
  int            mhits;
  int            mmisses;
  bit            mpend;

  logic [TN-1:0] tag_pool [4] = '{18'h01234, 18'h00ABC, 18'h3FFFF, 18'h15555};

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat(input int n);
    return (n > 15) ? 15 : n;
  endfunction

  task automatic model_flush();
    for (int s = 0; s < 256; s++) begin
      mv0[s] = 1'b0;
      mv1[s] = 1'b0;
      ml[s]  = 1'b0;
    end
  endtask

  task automatic model_reset();
    model_flush();
    mhits   = 0;
    mmisses = 0;
    mpend   = 1'b0;
  endtask

  // One complete L1 request, checked cycle by cycle against the model.
  task automatic req(input logic [IN-1:0] i, input logic [TN-1:0] t, input int mdelay,
                     input bit flush_req, input bit flush_busy, input bit stray_mem);
    bit h0, h1, vic;
    int acc_exp, waited;
    read_L1_L2  = 1'b1;
    index_L1_L2 = i;
    tag_L1_L2   = t;
    flush       = flush_req;
    acc_exp     = (flush_req || mpend) ? 2 : 1;
    if (flush_req || mpend) begin
      model_flush();
      mpend = 1'b0;
    end
    waited = 0;
    do begin
      step();
      flush = 1'b0;
      waited++;
    end while (busy !== 1'b1 && waited < 4);
    chk("accept_latency", waited, acc_exp);
    if (busy !== 1'b1) begin
      read_L1_L2 = 1'b0;
      return;
    end
    chk("compare_no_ready", 32'(ready_L2_L1), 0);

    h0 = mv0[i] && (mt0[i] == t);
    h1 = mv1[i] && (mt1[i] == t);
    if (stray_mem) ready_MEM_L2 = 1'b1;
    step();
    ready_MEM_L2 = 1'b0;
    if (flush_busy) flush = 1'b1;

    if (h0 || h1) begin
      mhits++;
      ml[i] = h0 ? 1'b1 : 1'b0;
      chk("hit_ready", 32'(ready_L2_L1), 1);
      chk("hit_no_memreq", 32'(read_L2_MEM), 0);
      chk("hit_no_refill", 32'(refill_L2), 0);
    end else begin
      mmisses++;
      if (!mv0[i]) vic = 1'b0;
      else if (!mv1[i]) vic = 1'b1;
      else vic = ml[i];
      chk("miss_memreq", 32'(read_L2_MEM), 1);
      chk("miss_index", 32'(index_L2_MEM), 32'(i));
      chk("miss_tag", 32'(tag_L2_MEM), 32'(t));
      chk("miss_no_ready", 32'(ready_L2_L1), 0);
      for (int k = 0; k < mdelay; k++) begin
        step();
        flush = 1'b0;
        chk("memreq_held", 32'(read_L2_MEM), 1);
      end
      ready_MEM_L2 = 1'b1;
      step();
      ready_MEM_L2 = 1'b0;
      flush = 1'b0;
      chk("refill_pulse", 32'(refill_L2), 1);
      chk("refill_way", 32'(way_L2), 32'(vic));
      chk("refill_no_ready", 32'(ready_L2_L1), 0);
      chk("refill_memreq_low", 32'(read_L2_MEM), 0);
      if (vic) begin mv1[i] = 1'b1; mt1[i] = t; end
      else     begin mv0[i] = 1'b1; mt0[i] = t; end
      ml[i] = ~vic;
      step();
      chk("miss_ready", 32'(ready_L2_L1), 1);
      chk("respond_no_refill", 32'(refill_L2), 0);
    end
    if (flush_busy) mpend = 1'b1;

    step();
    flush = 1'b0;
    chk("gap_ready_low", 32'(ready_L2_L1), 0);
    chk("gap_busy", 32'(busy), 1);
    step();
    chk("no_dup_accept", 32'(busy), 0);
    chk("idle_ready_low", 32'(ready_L2_L1), 0);
    read_L1_L2 = 1'b0;
    chk("hit_cnt", 32'(hit_cnt), 32'(sat(mhits)));
    chk("miss_cnt", 32'(miss_cnt), 32'(sat(mmisses)));
  endtask

  initial begin
    rst = 1'b1; read_L1_L2 = 1'b0; index_L1_L2 = '0; tag_L1_L2 = '0;
    flush = 1'b0; ready_MEM_L2 = 1'b0;
    model_reset();
    step();
    step();
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(ready_L2_L1), 0);
    chk("rst_refill", 32'(refill_L2), 0);
    chk("rst_way", 32'(way_L2), 0);
    chk("rst_memreq", 32'(read_L2_MEM), 0);
    chk("rst_index", 32'(index_L2_MEM), 0);
    chk("rst_tag", 32'(tag_L2_MEM), 0);
    chk("rst_hit_cnt", 32'(hit_cnt), 0);
    chk("rst_miss_cnt", 32'(miss_cnt), 0);

    // Cold miss, then hit, then way fill / LRU eviction sequence in set 0x05.
    req(8'h05, 18'h01234, 8, 1'b0, 1'b0, 1'b0);
    chk("cold_miss_cnt", 32'(miss_cnt), 1);
    req(8'h05, 18'h01234, 0, 1'b0, 1'b0, 1'b0);
    chk("repeat_hit_cnt", 32'(hit_cnt), 1);
    req(8'h05, 18'h00ABC, 2, 1'b0, 1'b0, 1'b0);
    req(8'h05, 18'h3FFFF, 1, 1'b0, 1'b0, 1'b1);
    req(8'h05, 18'h01234, 0, 1'b0, 1'b0, 1'b0);
    req(8'h05, 18'h00ABC, 3, 1'b0, 1'b0, 1'b0);

    // Flush while waiting on memory: request completes, line is gone after.
    req(8'h06, 18'h11111, 4, 1'b0, 1'b1, 1'b0);
    req(8'h06, 18'h11111, 2, 1'b0, 1'b0, 1'b0);
    // Flush and request together in IDLE: flush first, request one cycle later.
    req(8'h06, 18'h11111, 1, 1'b1, 1'b0, 1'b0);

    // Reset while in MEM_REQ aborts without a ready pulse.
    req(8'h07, 18'h00777, 1, 1'b0, 1'b0, 1'b0);
    req(8'h07, 18'h00777, 0, 1'b0, 1'b0, 1'b0);
    read_L1_L2 = 1'b1; index_L1_L2 = 8'h07; tag_L1_L2 = 18'h2AAAA;
    step();
    step();
    chk("pre_rst_memreq", 32'(read_L2_MEM), 1);
    rst = 1'b1;
    read_L1_L2 = 1'b0;
    step();
    rst = 1'b0;
    model_reset();
    chk("midrst_memreq", 32'(read_L2_MEM), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_ready", 32'(ready_L2_L1), 0);
    chk("midrst_miss_cnt", 32'(miss_cnt), 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("post_rst_no_ready", 32'(ready_L2_L1), 0);
    end
    req(8'h07, 18'h00777, 2, 1'b0, 1'b0, 1'b0);

    // Hit counter saturation.
    req(8'h09, 18'h12345, 0, 1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 20; n++) req(8'h09, 18'h12345, 0, 1'b0, 1'b0, 1'b0);
    chk("hit_cnt_saturated", 32'(hit_cnt), 32'hF);

    // Randomized traffic over a few hot sets and a small tag pool.
    for (int n = 0; n < 60; n++) begin
      logic [IN-1:0] ri;
      logic [TN-1:0] rt;
      ri = ($urandom_range(0, 3) == 0) ? IN'($urandom_range(0, 255)) : IN'(8'h05 + $urandom_range(0, 2));
      rt = ($urandom_range(0, 5) == 0) ? TN'($urandom) : tag_pool[$urandom_range(0, 3)];
      req(ri, rt, $urandom_range(0, 5), ($urandom_range(0, 11) == 0),
          ($urandom_range(0, 9) == 0), ($urandom_range(0, 4) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
